ring_osc_trim_seq: RTL
======================

RING_OSC_TRIM_SEQ -- requirements
Module: ring_osc_trim_seq

Interface
REQ-001 SHALL have parameter NSTAGES, default 13: number of two-trim-bit delay stages in the driven ring oscillator.
REQ-002 SHALL have parameter CODE_W, default $clog2(2*NSTAGES+1): width of the trim code.
REQ-003 SHALL have parameter SLEW_DIV, default 16, legal range 1 or more: clock cycles per trim step.
REQ-004 SHALL have parameter START_CYCLES, default 8, legal range 1 or more: cycles osc_reset is held after enable.
REQ-005 SHALL have one clock and an asynchronous active-low reset: `clock  in  1  sole clock`, all state on rising edge.
REQ-006 SHALL have `resetb  in  1  asynchronous active-low reset`.
REQ-007 SHALL have `enable  in  1  oscillator enable`, level-sensitive.
REQ-008 SHALL have `load  in  1  single-cycle strobe capturing target`.
REQ-009 SHALL have `target  in  CODE_W  requested trim code, 0..2*NSTAGES`.
REQ-010 SHALL have `trim_out  out  2*NSTAGES  stage trim vector`, with bit i as primary trim of stage i and bit NSTAGES+i as secondary trim of stage i.
REQ-011 SHALL have `osc_reset  out  1  active-high start-stage reset to oscillator`.
REQ-012 SHALL have `current  out  CODE_W  trim code presently applied`.
REQ-013 SHALL have `busy  out  1  high unless state RUN and current equals target_reg`.

Function
REQ-014 SHALL implement states OFF, START and RUN.
REQ-015 OFF SHALL drive osc_reset=1, current=0 and trim_out=0.
REQ-016 OFF SHALL go to START on the first edge with enable=1.
REQ-017 START SHALL drive osc_reset=1 and count START_CYCLES cycles, then go to RUN.
- osc_reset falls exactly START_CYCLES cycles after START is entered.
REQ-018 RUN SHALL drive osc_reset=0.
REQ-019 enable=0 in any state SHALL force OFF on the next edge, clearing current, trim_out, slew counter and start counter.
- target_reg is retained.
REQ-020 load=1 SHALL register target into target_reg in any state.
- A target value greater than 2*NSTAGES is clamped to 2*NSTAGES.
REQ-021 In RUN, the slew counter SHALL increment only while current != target_reg.
- When the counter equals SLEW_DIV-1, current moves one step toward target_reg and the counter clears.
- While current == target_reg, the counter holds 0.
REQ-022 current SHALL change by exactly one code per step and never skip codes.
- Consecutive steps are SLEW_DIV cycles apart.
REQ-023 A load arriving mid-slew SHALL redirect the slew with no counter reset.
- The slew continues from the present current value.
- If the new target equals current, slewing stops with the counter cleared.
REQ-024 When load and a step coincide on the same edge, the step SHALL use the old target_reg and the new target SHALL apply from the next cycle.
REQ-025 trim_out SHALL be a register updated on the same edge as current, decoded from the next value of current, with code k mapped as follows:
- k <= NSTAGES: bits [k-1:0] = 1, all others 0.
- k > NSTAGES: bits [NSTAGES-1:0] = 1, bits [NSTAGES+k-NSTAGES-1:NSTAGES] = 1, all others 0.
REQ-026 Consequence of REQ-025: a secondary bit SHALL never be 1 while its stage's primary bit is 0.
REQ-027 Consequence of REQ-022: trim_out SHALL change by exactly one bit per step.
REQ-028 busy SHALL be combinational from state, current and target_reg.

Reset
REQ-029 resetb=0 SHALL immediately, asynchronously, force the following: state OFF, osc_reset=1, current=0, trim_out=0, target_reg=0, all counters 0.
- Consequently busy=1.
REQ-030 Release of resetb SHALL take effect on the first rising clock edge after release.
- With enable=1 at that edge, the block enters START.

Verification
REQ-031 Reset then enable=1 (NSTAGES=13, START_CYCLES=8) -> osc_reset high for exactly 8 cycles; trim_out=0; busy falls once in RUN.
REQ-032 In RUN, load target=3 (SLEW_DIV=4) -> current steps 1,2,3 at 4-cycle spacing with no skips; trim_out=0x0000007; busy low after the last step.
REQ-033 Load target=15 from current 13 -> trim_out goes 0x0001FFF, then 0x0003FFF, then 0x0007FFF; load target=31 -> target_reg clamps to 26 and the final trim_out is 0x3FFFFFF.
REQ-034 Mid-slew from 0 toward 10, reload target=2 when current=5 -> current steps down 4,3,2 with no counter restart; reload equal to current -> slewing stops immediately.
REQ-035 enable=0 during a slew, then enable=1 -> current and trim_out are 0 on the next edge, the START sequence repeats, and slewing resumes toward the retained target_reg.
REQ-036 resetb asserted mid-slew with no clock edge -> all outputs reach their reset values at once; target_reg=0 after release.

Source files
------------

// File: rtl/ring_osc_trim_seq_if.sv
// Control/status bundle between a trim sequencer and the ring-oscillator side.
// Master drives enable/load/target; slave returns the trim vector and status.
interface ring_osc_trim_seq_if #(
    parameter int unsigned NSTAGES = 13,
    parameter int unsigned CODE_W  = $clog2(2*NSTAGES+1)
);
    logic                   enable;
    logic                   load;
    logic [CODE_W-1:0]      target;
    logic [2*NSTAGES-1:0]   trim_out;
    logic                   osc_reset;
    logic [CODE_W-1:0]      current;
    logic                   busy;

    modport master (
        output enable, load, target,
        input  trim_out, osc_reset, current, busy
    );

    modport slave (
        input  enable, load, target,
        output trim_out, osc_reset, current, busy
    );
endinterface

// File: rtl/ring_osc_trim_seq.sv
// Ring-oscillator trim sequencer: holds the oscillator in reset on enable, then slews
// the thermometer trim code one step per SLEW_DIV cycles toward a loaded target.
module ring_osc_trim_seq #(
    parameter int unsigned NSTAGES      = 13,
    parameter int unsigned CODE_W       = $clog2(2*NSTAGES+1),
    parameter int unsigned SLEW_DIV     = 16,
    parameter int unsigned START_CYCLES = 8
) (
    input logic                 clock,
    input logic                 resetb,
    ring_osc_trim_seq_if.slave  bus
);
    localparam int unsigned TrimW  = 2 * NSTAGES;
    localparam int unsigned SlewW  = (SLEW_DIV > 1) ? $clog2(SLEW_DIV) : 1;
    localparam int unsigned StartW = (START_CYCLES > 1) ? $clog2(START_CYCLES) : 1;
    localparam logic [CODE_W-1:0] MaxCode   = CODE_W'(TrimW);
    localparam logic [SlewW-1:0]  SlewLast  = SlewW'(SLEW_DIV - 1);
    localparam logic [StartW-1:0] StartLast = StartW'(START_CYCLES - 1);

    typedef enum logic [1:0] {StOff, StStart, StRun} state_e;

    state_e              state_q, state_d;
    logic [StartW-1:0]   start_cnt_q, start_cnt_d;
    logic [SlewW-1:0]    slew_cnt_q, slew_cnt_d;
    logic [CODE_W-1:0]   current_q, current_d;
    logic [CODE_W-1:0]   target_q, target_d;
    logic [TrimW-1:0]    trim_q, trim_d;

    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            state_q     <= StOff;
            start_cnt_q <= '0;
            slew_cnt_q  <= '0;
            current_q   <= '0;
            target_q    <= '0;
            trim_q      <= '0;
        end else begin
            state_q     <= state_d;
            start_cnt_q <= start_cnt_d;
            slew_cnt_q  <= slew_cnt_d;
            current_q   <= current_d;
            target_q    <= target_d;
            trim_q      <= trim_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        start_cnt_d = start_cnt_q;
        slew_cnt_d  = slew_cnt_q;
        current_d   = current_q;
        target_d    = target_q;

        // The step below still compares against target_q, so a coincident load waits a cycle.
        if (bus.load) begin
            target_d = (bus.target > MaxCode) ? MaxCode : bus.target;
        end

        if (!bus.enable) begin
            state_d     = StOff;
            start_cnt_d = '0;
            slew_cnt_d  = '0;
            current_d   = '0;
        end else begin
            unique case (state_q)
                StOff: begin
                    state_d     = StStart;
                    start_cnt_d = '0;
                end
                StStart: begin
                    if (start_cnt_q == StartLast) begin
                        state_d     = StRun;
                        start_cnt_d = '0;
                    end else begin
                        start_cnt_d = start_cnt_q + 1'b1;
                    end
                end
                StRun: begin
                    if (current_q != target_q) begin
                        if (slew_cnt_q == SlewLast) begin
                            slew_cnt_d = '0;
                            current_d  = (current_q < target_q) ? current_q + 1'b1
                                                                : current_q - 1'b1;
                        end else begin
                            slew_cnt_d = slew_cnt_q + 1'b1;
                        end
                    end else begin
                        slew_cnt_d = '0;
                    end
                end
                default: state_d = StOff;
            endcase
        end
    end

    // Thermometer decode: primaries fill first, then secondaries in stage order.
    always_comb begin
        trim_d = '0;
        for (int unsigned j = 0; j < TrimW; j++) begin
            trim_d[j] = (32'(current_d) > j);
        end
    end

    assign bus.trim_out  = trim_q;
    assign bus.osc_reset = (state_q != StRun);
    assign bus.current   = current_q;
    assign bus.busy      = !((state_q == StRun) && (current_q == target_q));

endmodule
